rk_ps2_rx: RTL
==============

// Module: rk_ps2_rx
// PURPOSE
//   PS/2 device-to-host frame receiver for the Radio-86RK keyboard path.
//   Synchronises and deglitches ps2_clk/ps2_dat, then assembles 11-bit frames
//   (start, 8 data LSB-first, odd parity, stop). Checks each frame and pushes
//   good scancode bytes into a show-ahead FIFO. The downstream keyboard matrix
//   decoder pops bytes (E0/F0 prefixes included) and updates its key state.
// PARAMETERS
//   FILTER_LEN  4      consecutive agreeing samples required to change filtered ps2_clk
//   TIMEOUT     100000 clk cycles without a falling edge before a partial frame is aborted
//   FIFO_AW     3      FIFO address width; depth = 2**FIFO_AW (8)
// PORTS
//   clk         in   1  system clock
//   reset       in   1  asynchronous, active-high reset
//   ps2_clk     in   1  raw PS/2 clock pin (asynchronous)
//   ps2_dat     in   1  raw PS/2 data pin (asynchronous)
//   rd          in   1  pop strobe; ignored when empty
//   dout        out  8  FIFO head byte; 8'h00 when empty
//   empty       out  1  FIFO empty
//   full        out  1  FIFO full
//   overflow    out  1  sticky: a good frame was dropped because the FIFO was full
//   clr_ovf     in   1  clears overflow; a new drop in the same cycle wins
//   parity_err  out  1  one-cycle pulse: frame rejected, parity not odd
//   frame_err   out  1  one-cycle pulse: stop bit sampled as 0
//   timeout     out  1  one-cycle pulse: partial frame aborted
// BEHAVIOUR
//   Reset values: empty=1, full=0, dout=0, overflow=0, all pulses 0, FSM IDLE,
//     FIFO pointers 0, bit counter 0, filtered clk=1, timeout counter 0.
//   Input path: 2-FF synchronisers on both pins. Filtered clk changes only after
//     FILTER_LEN consecutive synchronised samples agree. fall = 1-cycle strobe on
//     each 1->0 transition of filtered clk. The data bit is the synchronised
//     ps2_dat value in the fall cycle.
//   FSM (advances only on fall, except timeout):
//     IDLE:   dat=0 -> DATA, cnt=0; dat=1 -> stay in IDLE, no error.
//     DATA:   shift in bit at position cnt (LSB first); after 8th bit -> PARITY.
//     PARITY: latch bit -> STOP.
//     STOP:   if ^{data,par}==1 and dat==1, push. If parity is bad, pulse
//             parity_err. Else, if dat==0, pulse frame_err. Parity error takes
//             priority; only one error pulse per frame. Always -> IDLE.
//   Timeout: counter clears on every fall and while in IDLE. When outside IDLE
//     and the count reaches TIMEOUT-1: go to IDLE, pulse timeout, discard the
//     partial byte.
//   Latency: pin edge to fall strobe = 2 + FILTER_LEN clk cycles. The pushed byte
//     is visible on dout with empty=0 on the cycle after the stop-bit fall.
//   FIFO: registered memory with wrap-around pointers plus an FIFO_AW+1 bit count.
//     - Pop when rd & !empty; dout advances the next cycle.
//     - Push when full and no pop: byte dropped, overflow set.
//     - Push and pop in the same cycle when full: both occur, count unchanged,
//       no overflow.
//     - Push and rd in the same cycle when empty: push only; rd is ignored.
//   Reset mid-frame or mid-FIFO: all state returns to reset values immediately.
//     A frame in progress is lost, and the next start bit is received normally.
// TESTING
//   1 Frame 0x1C, ~40 us bit period, good parity -> empty falls, dout=8'h1C;
//     rd one cycle -> empty=1, dout=0.
//   2 Frames F0,1C,E0,75 back-to-back, no rd -> four pops return F0,1C,E0,75
//     in order; no error pulses.
//   3 Frame 0x5A with parity bit inverted -> one parity_err pulse; FIFO stays
//     empty. Frame 0x5A with stop=0 -> one frame_err pulse; FIFO stays empty.
//   4 Nine good frames 0x01..0x09, no rd -> full=1 after 8, overflow=1, pops
//     give 01..08. clr_ovf -> overflow=0. Then push+pop in the same cycle when
//     full -> count stays 8.
//   5 Start bit + 4 data bits, then clk idle high > TIMEOUT -> one timeout
//     pulse; next frame 0x76 is received as 8'h76. Glitches on ps2_clk shorter
//     than FILTER_LEN cycles during a frame are ignored, and the frame is
//     still received correctly.
//   6 Assert reset mid-frame with 3 bytes queued -> empty=1, overflow=0;
//     after release, frame 0x29 is received as 8'h29.

Source files
------------

// File: rtl/rk_ps2_rx.sv
// rk_ps2_rx: PS/2 device-to-host receiver for the Radio-86RK keyboard path.
//   Latency: pin edge to internal fall strobe is 2 + FILTER_LEN clk cycles; a good
//   byte appears on dout (empty=0) the cycle after the stop-bit fall strobe.
//   Backpressure: none toward the PS/2 device; a good byte arriving while the FIFO
//   is full (and not being popped) is dropped and the sticky overflow flag is set.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   ps2_clk/ps2_dat  raw asynchronous PS/2 pins
//   rd               pop strobe (ignored when empty)
//   dout             FIFO head byte, 8'h00 when empty (show-ahead)
//   empty/full       FIFO status
//   overflow         sticky drop flag, cleared by clr_ovf (a new drop wins)
//   parity_err       one-cycle pulse: frame rejected for even parity
//   frame_err        one-cycle pulse: stop bit sampled as 0
//   timeout          one-cycle pulse: partial frame abandoned
module rk_ps2_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 100000,
  parameter int FIFO_AW    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  input  logic       clr_ovf,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout
);

  localparam int FW    = $clog2(FILTER_LEN + 1);
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

  // --------------------------------------------------------------------------
  // Input synchronisers. Reset to 1 so an idle (pulled-up) bus produces no edge.
  // --------------------------------------------------------------------------
  logic clk_s1, clk_s2;
  logic dat_s1, dat_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Clock deglitch filter. flt_cnt counts consecutive synchronised samples that
  // disagree with the filtered level; the level flips on the FILTER_LEN-th one.
  // fall is taken combinationally from the flip condition so the FSM and FIFO
  // act on the same edge that updates clk_f.
  // --------------------------------------------------------------------------
  logic          clk_f;
  logic [FW-1:0] flt_cnt;
  logic          flt_flip;
  logic          fall;

  assign flt_flip = (clk_s2 != clk_f) && (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall     = flt_flip && clk_f;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_f   <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s2 == clk_f) begin
      flt_cnt <= '0;
    end else if (flt_flip) begin
      clk_f   <= clk_s2;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          par_ok;
  logic          push;
  logic          perr_set;
  logic          ferr_set;

  // A fall in the same cycle restarts the count, so it wins over an expiring timer.
  assign to_hit = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT - 1));
  // Odd parity over data plus parity bit.
  assign par_ok = ^{shift, par_bit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    perr_set  = 1'b0;
    ferr_set  = 1'b0;
    if (to_hit) begin
      state_nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) state_nxt = DATA;
        end
        DATA: begin
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          // Only one verdict per frame; bad parity outranks a bad stop bit.
          if (!par_ok) begin
            perr_set = 1'b1;
          end else if (!dat_s2) begin
            ferr_set = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      parity_err <= perr_set;
      frame_err  <= ferr_set;
      timeout    <= to_hit;

      if (fall || (state == IDLE) || to_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (to_hit) begin
        // Abandon the partial byte so nothing stale can leak into a later frame.
        bit_cnt <= '0;
        shift   <= '0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            shift   <= '0;
          end
          DATA: begin
            shift[bit_cnt] <= dat_s2;
            bit_cnt        <= bit_cnt + 1'b1;
          end
          PARITY: begin
            par_bit <= dat_s2;
          end
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead FIFO
  // --------------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;
  logic               do_pop, do_push, drop;

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW + 1)'(DEPTH));
  assign do_pop  = rd && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign dout    = empty ? 8'h00 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
